slink_ll_rx_pkt_router: RTL
===========================

SLINK_LL_RX_PKT_ROUTER -- requirements
Module: slink_ll_rx_pkt_router

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of application channels (1..8).
REQ-002 SHALL have parameter NUM_RULES, default 4, number of programmable match rules (1..16).
REQ-003 SHALL have parameter BYTES_PER_BEAT, default 4, payload bytes per valid beat (power of 2, 1..16).
REQ-004 SHALL have localparam CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- sop  in  1  start-of-packet qualifier.
- data_id  in  8  packet data ID, valid with sop.
- word_count  in  16  payload byte count, valid with sop.
- valid  in  1  beat valid.
- rule_en  in  NUM_RULES  per-rule enable.
- rule_id  in  8*NUM_RULES  per-rule match ID.
- rule_mask  in  8*NUM_RULES  per-rule bit mask; 1 = compare bit.
- rule_ch  in  CH_W*NUM_RULES  per-rule destination channel.
- drop_cnt_clr  in  1  clears drop counter.
- sop_app  out  NUM_CH  per-channel start of packet.
- valid_app  out  NUM_CH  per-channel beat valid.
- eop_app  out  NUM_CH  per-channel last beat.
- abort  out  1  one-cycle pulse: packet truncated by early sop.
- busy  out  1  state != IDLE.
- drop_cnt  out  16  dropped-packet count.

Function
REQ-006 Rule r SHALL match when rule_en[r] && ((data_id & rule_mask[r]) == (rule_id[r] & rule_mask[r])); lowest matching index wins.
REQ-007 Packets with data_id equal to NOP_DATAID or IDL_SYM SHALL always be dropped, regardless of rules.
REQ-008 Packets with no matching rule SHALL be dropped; a rule_ch value >= NUM_CH SHALL count as no match.
REQ-009 Packet length in beats SHALL be L = max(1, ceil(word_count/BYTES_PER_BEAT)); the sop beat counts as beat 1; arithmetic SHALL be 17-bit with no overflow.
REQ-010 The FSM SHALL have states IDLE, PASS and DROP.
REQ-011 FSM transitions:
- IDLE, sop&&valid: go to PASS or DROP per match; go to IDLE directly if L==1.
- PASS/DROP: each valid beat decrements the remaining count; the last beat returns to IDLE.
REQ-012 sop without valid SHALL be ignored; valid in IDLE without sop SHALL be ignored and not counted.
REQ-013 The routing decision and channel SHALL be latched at sop and held for the whole packet; rule inputs changing mid-packet SHALL NOT affect it.
REQ-014 Outputs SHALL be registered, exactly 1 cycle latency from the input beat.
- In PASS only the latched channel bit is driven: sop_app on beat 1, valid_app on every beat, eop_app on beat L.
- Other channel bits SHALL be 0; in DROP all channel bits SHALL be 0.
REQ-015 sop&&valid while in PASS/DROP SHALL:
- abort the current packet and pulse abort;
- emit no eop_app for the aborted packet;
- treat the beat as beat 1 of a new packet.
REQ-016 A single-beat packet (L==1) SHALL assert sop_app, valid_app and eop_app in the same cycle.

Reset
REQ-017 While reset is high at a clk edge:
- state SHALL go to IDLE;
- sop_app, valid_app, eop_app, abort and busy SHALL be 0 the next cycle;
- drop_cnt SHALL be 0.
REQ-018 Reset mid-packet SHALL discard the packet with no eop_app; the first sop after reset SHALL be decided normally.

Configuration
REQ-019 Macro SLINK_PKT_FILT_DROP_CNT_EN, when defined:
- drop_cnt SHALL increment by 1 per dropped packet at its sop beat (aborts not counted);
- drop_cnt SHALL saturate at 0xFFFF;
- drop_cnt_clr SHALL zero it, with priority over a same-cycle increment.
REQ-020 When SLINK_PKT_FILT_DROP_CNT_EN is undefined, drop_cnt SHALL be tied to 0, drop_cnt_clr SHALL be ignored and no counter flops SHALL exist.

Structure
REQ-021 NOP_DATAID, IDL_SYM and any shared data-ID constants SHALL come from the shared slink_includes.vh; nothing SHALL be redefined locally.
REQ-022 The rule comparison and priority encoder SHALL be a combinational sub-module, slink_ll_rx_pkt_match, outputting hit and channel.

Verification
REQ-023 Directed scenarios (NUM_CH=2, BYTES_PER_BEAT=4):
- Rule0 {en, id 0x22, mask 0xFF, ch 1}; packet 0x22, wc=10 -> 3 beats on ch1: sop_app=2'b10 on beat 1, eop_app=2'b10 on beat 3, ch0 silent, 1-cycle latency.
- NOP_DATAID packet with rule0 mask 0x00 (matches everything) -> no outputs; drop_cnt=1.
- Rules 0 {0x20, mask 0xF0, ch 0} and 1 {0x22, 0xFF, ch 1}; id 0x22 -> routed to ch0 (priority).
- wc=0 and wc=3 packets -> single beat each, sop/valid/eop_app together.
- 4-beat packet, new sop on beat 2 -> abort pulses, no eop for first packet, second packet routed correctly.
- Counter enabled: 0xFFFF drops followed by 2 more -> drop_cnt=0xFFFF; drop_cnt_clr -> 0; reset mid-packet -> busy=0 next cycle.

Source files
------------

// File: rtl/slink_ll_rx_pkt_router_pkg.sv
// Types, FSM encodings and helpers shared by the S-Link RX packet router.
`include "slink_includes.vh"

package slink_ll_rx_pkt_router_pkg;

  // state   | meaning
  // IDLE    | waiting for sop&&valid
  // PASS    | forwarding beats of a matched packet to the latched channel
  // DROP    | swallowing beats of a filtered packet
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [7:0] PKT_NOP_ID = `NOP_DATAID;
  localparam logic [7:0] PKT_IDL_ID = `IDL_SYM;

  typedef logic [16:0] beat_cnt_t;

  // 17-bit so word_count + BYTES_PER_BEAT-1 cannot wrap near 0xFFFF.
  function automatic beat_cnt_t pkt_beats(input logic [15:0] wc, input int unsigned shift);
    beat_cnt_t sum;
    beat_cnt_t beats;
    sum   = {1'b0, wc} + ((17'd1 << shift) - 17'd1);
    beats = sum >> shift;
    if (beats == '0) beats = 17'd1;
    return beats;
  endfunction

  function automatic logic is_filler_id(input logic [7:0] id);
    return (id == PKT_NOP_ID) || (id == PKT_IDL_ID);
  endfunction

endpackage

// File: rtl/slink_includes.vh
// Shared S-Link data-ID constants used by the link-layer blocks.
`ifndef SLINK_INCLUDES_VH
`define SLINK_INCLUDES_VH

`define IDL_SYM    8'h00
`define NOP_DATAID 8'h01

`endif

// File: rtl/slink_ll_rx_pkt_match.sv
// Combinational rule compare and priority encoder: lowest matching rule index wins.
module slink_ll_rx_pkt_match
  import slink_ll_rx_pkt_router_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int NUM_RULES = 4,
  parameter int CH_W      = 1
) (
  input  logic [7:0]              data_id,
  input  logic [NUM_RULES-1:0]    rule_en,
  input  logic [8*NUM_RULES-1:0]  rule_id,
  input  logic [8*NUM_RULES-1:0]  rule_mask,
  input  logic [CH_W*NUM_RULES-1:0] rule_ch,
  output logic                    hit,
  output logic [CH_W-1:0]         ch
);

  always_comb begin
    hit = 1'b0;
    ch  = '0;
    // Walk downward so the lowest matching index is the last to overwrite.
    for (int r = NUM_RULES - 1; r >= 0; r--) begin
      if (rule_en[r] &&
          ((data_id & rule_mask[r*8 +: 8]) == (rule_id[r*8 +: 8] & rule_mask[r*8 +: 8])) &&
          (32'(rule_ch[r*CH_W +: CH_W]) < NUM_CH)) begin
        hit = 1'b1;
        ch  = rule_ch[r*CH_W +: CH_W];
      end
    end
  end

endmodule

// File: rtl/slink_ll_rx_pkt_router.sv
// S-Link RX packet router: filters packets by data ID and steers beats to a channel.
// Optional drop counter enabled by defining SLINK_PKT_FILT_DROP_CNT_EN.
module slink_ll_rx_pkt_router
  import slink_ll_rx_pkt_router_pkg::*;
#(
  parameter int  NUM_CH         = 2,
  parameter int  NUM_RULES      = 4,
  parameter int  BYTES_PER_BEAT = 4,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sop,
  input  logic [7:0]                data_id,
  input  logic [15:0]               word_count,
  input  logic                      valid,
  input  logic [NUM_RULES-1:0]      rule_en,
  input  logic [8*NUM_RULES-1:0]    rule_id,
  input  logic [8*NUM_RULES-1:0]    rule_mask,
  input  logic [CH_W*NUM_RULES-1:0] rule_ch,
  input  logic                      drop_cnt_clr,
  output logic [NUM_CH-1:0]         sop_app,
  output logic [NUM_CH-1:0]         valid_app,
  output logic [NUM_CH-1:0]         eop_app,
  output logic                      abort,
  output logic                      busy,
  output logic [15:0]               drop_cnt
);

  localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);

  logic [1:0]        state_q, state_d;
  beat_cnt_t         rem_q, rem_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] sop_d, valid_d, eop_d;
  logic              abort_d;
  logic              drop_inc;

  logic              match_hit;
  logic [CH_W-1:0]   match_ch;
  logic              pass_new;
  beat_cnt_t         new_beats;
  logic [NUM_CH-1:0] new_sel, cur_sel;

  slink_ll_rx_pkt_match #(
    .NUM_CH    (NUM_CH),
    .NUM_RULES (NUM_RULES),
    .CH_W      (CH_W)
  ) u_match (
    .data_id   (data_id),
    .rule_en   (rule_en),
    .rule_id   (rule_id),
    .rule_mask (rule_mask),
    .rule_ch   (rule_ch),
    .hit       (match_hit),
    .ch        (match_ch)
  );

  assign pass_new  = match_hit && !is_filler_id(data_id);
  assign new_beats = pkt_beats(word_count, BEAT_SHIFT);
  assign new_sel   = NUM_CH'(1) << match_ch;
  assign cur_sel   = NUM_CH'(1) << ch_q;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ch_d     = ch_q;
    sop_d    = '0;
    valid_d  = '0;
    eop_d    = '0;
    abort_d  = 1'b0;
    drop_inc = 1'b0;
    if (valid && sop) begin
      // A sop mid-packet truncates the old packet and starts a fresh one.
      abort_d  = (state_q != ST_IDLE);
      ch_d     = match_ch;
      rem_d    = new_beats - 17'd1;
      drop_inc = !pass_new;
      if (pass_new) begin
        sop_d   = new_sel;
        valid_d = new_sel;
        if (new_beats == 17'd1) eop_d = new_sel;
      end
      if (new_beats == 17'd1) state_d = ST_IDLE;
      else                    state_d = pass_new ? ST_PASS : ST_DROP;
    end else if (valid && (state_q != ST_IDLE)) begin
      rem_d = rem_q - 17'd1;
      if (state_q == ST_PASS) begin
        valid_d = cur_sel;
        if (rem_q == 17'd1) eop_d = cur_sel;
      end
      if (rem_q <= 17'd1) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      ch_q      <= '0;
      sop_app   <= '0;
      valid_app <= '0;
      eop_app   <= '0;
      abort     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ch_q      <= ch_d;
      sop_app   <= sop_d;
      valid_app <= valid_d;
      eop_app   <= eop_d;
      abort     <= abort_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef SLINK_PKT_FILT_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || drop_cnt_clr) begin
      drop_cnt_q <= '0;
    end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop_cnt_clr ^ drop_inc;
  assign drop_cnt    = '0;
`endif

endmodule
